// File: rtl/spi_cmd_pkg.sv
// SPI command engine shared definitions: command/reply codes and FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a. The host-side bench model imports the same codes.
package spi_cmd_pkg;

    // Host -> FPGA command words
    localparam logic [15:0] CMD_START   = 16'd1;
    localparam logic [15:0] CMD_WRITE   = 16'd2;
    localparam logic [15:0] CMD_READ    = 16'd3;
    localparam logic [15:0] CMD_SD_READ = 16'd5;
    localparam logic [15:0] CMD_STOP    = 16'd22;

    // FPGA -> host reply words
    localparam logic [15:0] RPL_SUCCESS = 16'd20;
    localparam logic [15:0] RPL_FAIL    = 16'd27;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_CMD   = 3'd1,
        ST_GET_ADDR  = 3'd2,
        ST_RD_WAIT   = 3'd3,
        ST_GET_WDATA = 3'd4,
        ST_GET_STOP  = 3'd5,
        ST_SD_STREAM = 3'd6,
        ST_ERR_STOP  = 3'd7
    } state_t;

    // Saturating 8-bit increment for the protocol error counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_cmd_slave_if.sv
// Bus bundle between the SPI word shifter, the command engine and the register memory map.
// Latency: n/a (wires only).
// Backpressure: none; word_rx_valid is a 1-cycle pulse and the host paces words.
//  spi_ss_p / word_rx_*      : from word shifter (host side)
//  word_tx_data              : reply preloaded for the next SPI word
//  mm_wr_* / mm_rd_*         : register memory-map access
//  fifo_*                    : SD stream FIFO (used only with SPI_SD_STREAM_EN)
interface spi_cmd_slave_if;
    import spi_cmd_pkg::*;

    logic        spi_ss_p;
    logic [15:0] word_rx_data;
    logic        word_rx_valid;
    logic [15:0] word_tx_data;

    logic        mm_wr_en;
    logic [15:0] mm_wr_addr;
    logic [15:0] mm_wr_data;
    logic        mm_rd_en;
    logic [15:0] mm_rd_addr;
    logic [15:0] mm_rd_data;

    logic        fifo_rd_en;
    logic [15:0] fifo_data;
    logic        fifo_empty;

    // Command engine side
    modport slave (
        input  spi_ss_p, word_rx_data, word_rx_valid, mm_rd_data, fifo_data, fifo_empty,
        output word_tx_data, mm_wr_en, mm_wr_addr, mm_wr_data, mm_rd_en, mm_rd_addr, fifo_rd_en
    );

    // Environment side (shifter + memory map + FIFO)
    modport master (
        output spi_ss_p, word_rx_data, word_rx_valid, mm_rd_data, fifo_data, fifo_empty,
        input  word_tx_data, mm_wr_en, mm_wr_addr, mm_wr_data, mm_rd_en, mm_rd_addr, fifo_rd_en
    );

endinterface

// File: rtl/spi_cmd_slave.sv
// SPI command engine: decodes START/cmd/addr/data/STOP words, drives memory-map reads/writes,
// preloads each reply word. Latency: write strobe 1 cycle after data word; read reply loaded
// RD_LAT+1 cycles after address word. Backpressure: none, host guarantees >=6-cycle word gap.
//  Ports: clk210_p (only clock), reset_p (async, active high), bus (spi_cmd_slave_if.slave),
//         err_cnt (saturating protocol error count), busy (FSM not IDLE).
//  Optional feature macro: SPI_SD_STREAM_EN enables the SD_READ burst command.
module spi_cmd_slave
    import spi_cmd_pkg::*;
#(
    parameter int RD_LAT    = 2,    // memory-map read latency, 1..4
    parameter int WORDS_BLK = 509   // words per SD burst
) (
    input  logic            clk210_p,
    input  logic            reset_p,
    spi_cmd_slave_if.slave  bus,
    output logic [7:0]      err_cnt,
    output logic            busy
);

    localparam logic [2:0] RD_CNT_INIT = 3'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [15:0] tx_q, tx_d;
    logic [7:0]  err_q;
    logic        err_inc;
    logic        cmd_rd_q, cmd_rd_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        rd_strobe;
    logic [2:0]  rd_cnt_q, rd_cnt_d;
    logic        ss_q;
    logic        abort;
    logic        rx_vld;
    logic [15:0] rx;
    logic        fifo_pop;

`ifdef SPI_SD_STREAM_EN
    localparam int SD_W = $clog2(WORDS_BLK + 1);
    logic [SD_W-1:0] sd_cnt_q, sd_cnt_d;
`else
    logic unused_fifo;
    assign unused_fifo = ^{bus.fifo_data, bus.fifo_empty, 32'(WORDS_BLK)};
`endif

    assign rx_vld = bus.word_rx_valid;
    assign rx     = bus.word_rx_data;

    // Slave-select rising edge (deassert) aborts whatever is in flight; it
    // dominates a word arriving in the same cycle.
    assign abort = bus.spi_ss_p & ~ss_q;

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        err_inc   = 1'b0;
        cmd_rd_d  = cmd_rd_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_strobe = 1'b0;
        rd_cnt_d  = rd_cnt_q;
        fifo_pop  = 1'b0;
`ifdef SPI_SD_STREAM_EN
        sd_cnt_d  = sd_cnt_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
            tx_d    = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_d = 16'h0000;
                    if (rx_vld) begin
                        if (rx == CMD_START) begin
                            tx_d    = RPL_SUCCESS;
                            state_d = ST_GET_CMD;
                        end else begin
                            tx_d    = RPL_FAIL;
                            err_inc = 1'b1;
                            state_d = ST_ERR_STOP;
                        end
                    end
                end
                ST_GET_CMD: begin
                    if (rx_vld) begin
                        case (rx)
                            CMD_WRITE, CMD_READ: begin
                                cmd_rd_d = (rx == CMD_READ);
                                tx_d     = RPL_SUCCESS;
                                state_d  = ST_GET_ADDR;
                            end
`ifdef SPI_SD_STREAM_EN
                            CMD_SD_READ: begin
                                tx_d     = RPL_SUCCESS;
                                sd_cnt_d = '0;
                                state_d  = ST_SD_STREAM;
                            end
`endif
                            default: begin
                                tx_d    = RPL_FAIL;
                                err_inc = 1'b1;
                                state_d = ST_ERR_STOP;
                            end
                        endcase
                    end
                end
                ST_GET_ADDR: begin
                    if (rx_vld) begin
                        if (cmd_rd_q) begin
                            // Strobe the read in the address cycle itself so the
                            // reply is ready well before the next word.
                            rd_strobe = 1'b1;
                            rd_addr_d = rx;
                            rd_cnt_d  = RD_CNT_INIT;
                            state_d   = ST_RD_WAIT;
                        end else begin
                            wr_addr_d = rx;
                            tx_d      = RPL_SUCCESS;
                            state_d   = ST_GET_WDATA;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (rx_vld) begin
                        // Host did not leave room for the read: flag it, keep old reply.
                        err_inc = 1'b1;
                        state_d = ST_ERR_STOP;
                    end else if (rd_cnt_q == 3'd0) begin
                        tx_d    = bus.mm_rd_data;
                        state_d = ST_GET_STOP;
                    end else begin
                        rd_cnt_d = rd_cnt_q - 3'd1;
                    end
                end
                ST_GET_WDATA: begin
                    if (rx_vld) begin
                        wr_data_d = rx;
                        wr_en_d   = 1'b1;
                        tx_d      = RPL_SUCCESS;
                        state_d   = ST_GET_STOP;
                    end
                end
                ST_GET_STOP, ST_ERR_STOP: begin
                    if (rx_vld) begin
                        tx_d    = 16'h0000;
                        state_d = ST_IDLE;
                    end
                end
                ST_SD_STREAM: begin
`ifdef SPI_SD_STREAM_EN
                    if (rx_vld) begin
                        if (bus.fifo_empty) begin
                            tx_d    = RPL_FAIL;
                            state_d = ST_GET_STOP;
                        end else begin
                            tx_d     = bus.fifo_data;
                            fifo_pop = 1'b1;
                            sd_cnt_d = sd_cnt_q + 1'b1;
                            if (sd_cnt_q == SD_W'(WORDS_BLK - 1))
                                state_d = ST_GET_STOP;
                        end
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk210_p or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= ST_IDLE;
            tx_q      <= 16'h0000;
            err_q     <= 8'h00;
            cmd_rd_q  <= 1'b0;
            wr_addr_q <= 16'h0000;
            wr_data_q <= 16'h0000;
            wr_en_q   <= 1'b0;
            rd_addr_q <= 16'h0000;
            rd_cnt_q  <= 3'd0;
            ss_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            if (err_inc)
                err_q <= sat_inc8(err_q);
            cmd_rd_q  <= cmd_rd_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_cnt_q  <= rd_cnt_d;
            ss_q      <= bus.spi_ss_p;
        end
    end

`ifdef SPI_SD_STREAM_EN
    always_ff @(posedge clk210_p or posedge reset_p) begin
        if (reset_p)
            sd_cnt_q <= '0;
        else
            sd_cnt_q <= sd_cnt_d;
    end
    assign bus.fifo_rd_en = fifo_pop;
`else
    assign bus.fifo_rd_en = 1'b0;
`endif

    assign bus.word_tx_data = tx_q;
    assign bus.mm_wr_en     = wr_en_q;
    assign bus.mm_wr_addr   = wr_addr_q;
    assign bus.mm_wr_data   = wr_data_q;
    assign bus.mm_rd_en     = rd_strobe;
    assign bus.mm_rd_addr   = rd_strobe ? rx : rd_addr_q;
    assign err_cnt          = err_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench for spi_cmd_slave: host word sequences with hand-computed replies,
// a RD_LAT=2 memory-map model and a small SD FIFO model.
module tb_spi_cmd_slave;
    import spi_cmd_pkg::*;

    logic       clk210_p = 1'b0;
    logic       reset_p;
    logic [7:0] err_cnt;
    logic       busy;

    always #2 clk210_p = ~clk210_p;

    spi_cmd_slave_if bus();

    spi_cmd_slave #(.RD_LAT(2), .WORDS_BLK(509)) dut (
        .clk210_p (clk210_p),
        .reset_p  (reset_p),
        .bus      (bus),
        .err_cnt  (err_cnt),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory-map model: data appears exactly 2 cycles after a strobe; non-strobe
    // cycles push a marker so a wrong sample time returns wrong data.
    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return (a == 16'h0004) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    logic [15:0] rd_pipe0 = 16'hDEAD;
    logic [15:0] rd_pipe1 = 16'hDEAD;
    assign bus.mm_rd_data = mem_rd(rd_pipe1);

    // SD FIFO model (first-word-fall-through)
    logic [15:0] fifo_arr [0:3];
    int          fifo_head = 0;
    int          fifo_cnt  = 0;
    assign bus.fifo_empty = (fifo_head >= fifo_cnt);
    assign bus.fifo_data  = fifo_arr[fifo_head[1:0]];

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          pop_cnt = 0;
    logic [15:0] last_wr_addr = 16'h0;
    logic [15:0] last_wr_data = 16'h0;
    logic [15:0] last_rd_addr = 16'h0;

    always @(posedge clk210_p) begin
        rd_pipe0 <= bus.mm_rd_en ? bus.mm_rd_addr : 16'hDEAD;
        rd_pipe1 <= rd_pipe0;
        if (bus.mm_wr_en) begin
            wr_cnt++;
            last_wr_addr = bus.mm_wr_addr;
            last_wr_data = bus.mm_wr_data;
        end
        if (bus.mm_rd_en) begin
            rd_cnt++;
            last_rd_addr = bus.mm_rd_addr;
        end
        if (bus.fifo_rd_en) begin
            pop_cnt++;
            fifo_head++;
        end
    end

    // One host word: 1-cycle valid pulse, then a 7-cycle gap.
    task automatic send_word(input logic [15:0] w);
        @(negedge clk210_p);
        bus.word_rx_data  = w;
        bus.word_rx_valid = 1'b1;
        @(negedge clk210_p);
        bus.word_rx_valid = 1'b0;
        repeat (7) @(negedge clk210_p);
    endtask

    task automatic word_chk(input string tag, input logic [15:0] w, input logic [15:0] exp_tx);
        send_word(w);
        check_val(tag, bus.word_tx_data, exp_tx);
    endtask

    int exp_err = 0;
    int wr0, rd0;

    initial begin
        reset_p           = 1'b1;
        bus.spi_ss_p      = 1'b0;
        bus.word_rx_valid = 1'b0;
        bus.word_rx_data  = 16'h0;
        fifo_arr[0] = 16'hA001; fifo_arr[1] = 16'hA002;
        fifo_arr[2] = 16'hA003; fifo_arr[3] = 16'h0000;
        repeat (3) @(negedge clk210_p);

        // Reset state
        check_val("rst_tx",   bus.word_tx_data, 16'h0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err",  err_cnt, 0);
        check_val("rst_wr",   bus.mm_wr_en, 0);
        check_val("rst_rd",   bus.mm_rd_en, 0);
        check_val("rst_pop",  bus.fifo_rd_en, 0);
        reset_p = 1'b0;
        repeat (2) @(negedge clk210_p);

        // 1. Write
        word_chk("w_start", CMD_START, RPL_SUCCESS);
        word_chk("w_cmd",   CMD_WRITE, RPL_SUCCESS);
        word_chk("w_addr",  16'h0010,  RPL_SUCCESS);
        check_val("w_no_early_strobe", wr_cnt, 0);
        word_chk("w_data",  16'hBEEF,  RPL_SUCCESS);
        check_val("w_cnt",  wr_cnt, 1);
        check_val("w_addr_out", last_wr_addr, 16'h0010);
        check_val("w_data_out", last_wr_data, 16'hBEEF);
        check_val("w_busy", busy, 1);
        word_chk("w_stop",  CMD_STOP,  16'h0);
        check_val("w_idle", busy, 0);

        // 2. Read, mm[0x0004]=0x1234
        word_chk("r_start", CMD_START, RPL_SUCCESS);
        word_chk("r_cmd",   CMD_READ,  RPL_SUCCESS);
        word_chk("r_addr",  16'h0004,  16'h1234);
        check_val("r_cnt",  rd_cnt, 1);
        check_val("r_addr_out", last_rd_addr, 16'h0004);
        word_chk("r_stop",  CMD_STOP,  16'h0);

        // Read reply timing: loaded exactly RD_LAT+1 cycles after the address pulse
        word_chk("rt_start", CMD_START, RPL_SUCCESS);
        word_chk("rt_cmd",   CMD_READ,  RPL_SUCCESS);
        @(negedge clk210_p);
        bus.word_rx_data  = 16'h0020;
        bus.word_rx_valid = 1'b1;
        @(negedge clk210_p);
        bus.word_rx_valid = 1'b0;
        @(negedge clk210_p);
        check_val("rt_not_yet", bus.word_tx_data, RPL_SUCCESS);
        @(negedge clk210_p);
        check_val("rt_loaded", bus.word_tx_data, 16'hA585);
        repeat (6) @(negedge clk210_p);
        word_chk("rt_stop", CMD_STOP, 16'h0);
        check_val("rt_err", err_cnt, 0);

        // 3. Bad start, then bad command
        word_chk("bad_start", 16'd7, RPL_FAIL);
        exp_err++;
        check_val("bad_start_err", err_cnt, exp_err);
        word_chk("bad_start_rec", CMD_STOP, 16'h0);
        word_chk("bc_start", CMD_START, RPL_SUCCESS);
        word_chk("bad_cmd",  16'd9, RPL_FAIL);
        exp_err++;
        check_val("bad_cmd_err", err_cnt, exp_err);
        word_chk("bad_cmd_rec", 16'h0, 16'h0);

        // Word arriving during RD_WAIT: error, reply left as is
        word_chk("rw_start", CMD_START, RPL_SUCCESS);
        word_chk("rw_cmd",   CMD_READ,  RPL_SUCCESS);
        @(negedge clk210_p);
        bus.word_rx_data  = 16'h0004;
        bus.word_rx_valid = 1'b1;
        @(negedge clk210_p);
        bus.word_rx_valid = 1'b0;
        send_word(16'h0000);
        exp_err++;
        check_val("rw_tx_kept", bus.word_tx_data, RPL_SUCCESS);
        check_val("rw_err", err_cnt, exp_err);
        check_val("rw_busy", busy, 1);
        word_chk("rw_rec", CMD_STOP, 16'h0);

        // 4. Abort after write address
        wr0 = wr_cnt;
        word_chk("ab_start", CMD_START, RPL_SUCCESS);
        word_chk("ab_cmd",   CMD_WRITE, RPL_SUCCESS);
        word_chk("ab_addr",  16'h0030,  RPL_SUCCESS);
        @(negedge clk210_p);
        bus.spi_ss_p = 1'b1;
        repeat (4) @(negedge clk210_p);
        check_val("ab_tx",   bus.word_tx_data, 16'h0);
        check_val("ab_busy", busy, 0);
        bus.spi_ss_p = 1'b0;
        repeat (2) @(negedge clk210_p);
        // Abort coinciding with the data word: word discarded
        word_chk("ab2_start", CMD_START, RPL_SUCCESS);
        word_chk("ab2_cmd",   CMD_WRITE, RPL_SUCCESS);
        word_chk("ab2_addr",  16'h0040,  RPL_SUCCESS);
        @(negedge clk210_p);
        bus.spi_ss_p      = 1'b1;
        bus.word_rx_data  = 16'h1111;
        bus.word_rx_valid = 1'b1;
        @(negedge clk210_p);
        bus.word_rx_valid = 1'b0;
        repeat (4) @(negedge clk210_p);
        check_val("ab_no_write", wr_cnt, wr0);
        check_val("ab2_busy", busy, 0);
        check_val("ab2_err",  err_cnt, exp_err);
        bus.spi_ss_p = 1'b0;
        repeat (2) @(negedge clk210_p);
        word_chk("ab_restart", CMD_START, RPL_SUCCESS);
        word_chk("ab_r_cmd",   CMD_WRITE, RPL_SUCCESS);
        word_chk("ab_r_addr",  16'h0050,  RPL_SUCCESS);
        word_chk("ab_r_data",  16'h5A5A,  RPL_SUCCESS);
        check_val("ab_r_cnt",  wr_cnt, wr0 + 1);
        check_val("ab_r_waddr", last_wr_addr, 16'h0050);
        word_chk("ab_r_stop",  CMD_STOP,  16'h0);

        // 5. SD stream
`ifdef SPI_SD_STREAM_EN
        fifo_head = 0;
        fifo_cnt  = 3;
        word_chk("sd_start", CMD_START,   RPL_SUCCESS);
        word_chk("sd_cmd",   CMD_SD_READ, RPL_SUCCESS);
        word_chk("sd_w0",    16'h0, 16'hA001);
        word_chk("sd_w1",    16'h0, 16'hA002);
        word_chk("sd_w2",    16'h0, 16'hA003);
        word_chk("sd_empty", 16'h0, RPL_FAIL);
        check_val("sd_pops", pop_cnt, 3);
        check_val("sd_busy", busy, 1);
        word_chk("sd_stop",  CMD_STOP, 16'h0);
        check_val("sd_idle", busy, 0);
        check_val("sd_err",  err_cnt, exp_err);
`else
        word_chk("sd_start", CMD_START,   RPL_SUCCESS);
        word_chk("sd_cmd_rej", CMD_SD_READ, RPL_FAIL);
        exp_err++;
        check_val("sd_err", err_cnt, exp_err);
        word_chk("sd_rec", CMD_STOP, 16'h0);
        check_val("sd_no_pop", pop_cnt, 0);
`endif

        // 6. Reset during RD_WAIT
        rd0 = rd_cnt;
        word_chk("rr_start", CMD_START, RPL_SUCCESS);
        word_chk("rr_cmd",   CMD_READ,  RPL_SUCCESS);
        @(negedge clk210_p);
        bus.word_rx_data  = 16'h0004;
        bus.word_rx_valid = 1'b1;
        @(negedge clk210_p);
        bus.word_rx_valid = 1'b0;
        reset_p = 1'b1;
        @(negedge clk210_p);
        reset_p = 1'b0;
        repeat (5) @(negedge clk210_p);
        check_val("rr_tx",   bus.word_tx_data, 16'h0);
        check_val("rr_busy", busy, 0);
        check_val("rr_err",  err_cnt, 0);
        check_val("rr_wr",   bus.mm_wr_en, 0);
        check_val("rr_rd_once", rd_cnt, rd0 + 1);
        word_chk("rr2_start", CMD_START, RPL_SUCCESS);
        word_chk("rr2_cmd",   CMD_READ,  RPL_SUCCESS);
        word_chk("rr2_addr",  16'h0004,  16'h1234);
        word_chk("rr2_stop",  CMD_STOP,  16'h0);

        // Error counter saturation
        for (int i = 0; i < 255; i++) begin
            send_word(16'd7);
            send_word(CMD_STOP);
        end
        check_val("sat_255", err_cnt, 255);
        for (int i = 0; i < 2; i++) begin
            send_word(16'd7);
            send_word(CMD_STOP);
        end
        check_val("sat_hold", err_cnt, 255);
        check_val("sat_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
